alu_writeback: RTL and testbench

- Stage directly downstream of the ALU. Captures ALU result and flags and owns the status register (SREG). SREG is fed back to the ALU `flags_in` input.
- Buffers register-file writes in a 2-entry queue with a valid/ready handshake to the register-file write port.
- Flags read-after-write hazards on pending register writes so the upstream control can stall.

---
 rtl/alu_writeback.sv | 143 ++++++++++++++
 tb/tb_alu_writeback.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// ALU writeback: owns SREG, queues register-file writes (2 deep), flags RAW hazards on queued writes.
// Latency: SREG updates on the accepting edge; register write appears on rf_wr_* one cycle after accept.
// Backpressure: rf_wr_ready low holds the head entry; in_ready drops when 2 writes are queued. WB_BYPASS_EN adds forwarding.
module alu_writeback #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] in_flags,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  in_wr_rf,
    input  logic                  in_wr_sreg,
    input  logic                  bit_op_valid,
    input  logic                  bit_op_set,
    input  logic [2:0]            bit_op_idx,
    output logic [DATA_WIDTH-1:0] sreg,
    output logic                  rf_wr_en,
    input  logic                  rf_wr_ready,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    input  logic [ADDR_WIDTH-1:0] chk_addr_a,
    input  logic [ADDR_WIDTH-1:0] chk_addr_b,
    output logic                  hazard
`ifdef WB_BYPASS_EN
    ,
    output logic                  byp_a_valid,
    output logic [DATA_WIDTH-1:0] byp_a_data,
    output logic                  byp_b_valid,
    output logic [DATA_WIDTH-1:0] byp_b_data
`endif
);

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_ent_t;

    q_state_t              state, state_nxt;
    wb_ent_t               ent_q [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            ent_vld;
    logic [1:0]            match_a, match_b;
    logic                  accept, push, pop;
    logic [DATA_WIDTH-1:0] sreg_nxt;

    assign in_ready = (state != Q_FULL) & ~reset;
    assign accept   = in_valid & in_ready;
    assign push     = accept & in_wr_rf;
    assign rf_wr_en = (state != Q_EMPTY);
    assign pop      = rf_wr_en & rf_wr_ready;

    assign rf_wr_addr = ent_q[rd_ptr].addr;
    assign rf_wr_data = ent_q[rd_ptr].data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= Q_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            Q_EMPTY: if (push) state_nxt = Q_ONE;
            Q_ONE: begin
                if (push && !pop)      state_nxt = Q_FULL;
                else if (!push && pop) state_nxt = Q_EMPTY;
            end
            Q_FULL:  if (pop) state_nxt = Q_ONE;
            default: state_nxt = Q_EMPTY;
        endcase
    end

    // Entry storage is cleared on reset so the write port reads zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            if (push) begin
                ent_q[wr_ptr] <= '{addr: in_addr, data: in_data};
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Flags land first, then a same-cycle bit op overrides just its bit.
    always_comb begin
        sreg_nxt = sreg;
        if (accept && in_wr_sreg) sreg_nxt = in_flags;
        if (bit_op_valid)         sreg_nxt[bit_op_idx] = bit_op_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
        end else begin
            sreg <= sreg_nxt;
        end
    end

    always_comb begin
        ent_vld = 2'b00;
        case (state)
            Q_ONE:   ent_vld[rd_ptr] = 1'b1;
            Q_FULL:  ent_vld = 2'b11;
            default: ent_vld = 2'b00;
        endcase
        for (int i = 0; i < 2; i++) begin
            match_a[i] = ent_vld[i] & (ent_q[i].addr == chk_addr_a);
            match_b[i] = ent_vld[i] & (ent_q[i].addr == chk_addr_b);
        end
    end

`ifdef WB_BYPASS_EN
    // The youngest entry always sits just behind the write pointer.
    assign hazard      = 1'b0;
    assign byp_a_valid = |match_a;
    assign byp_b_valid = |match_b;
    assign byp_a_data  = match_a[~wr_ptr] ? ent_q[~wr_ptr].data : ent_q[wr_ptr].data;
    assign byp_b_data  = match_b[~wr_ptr] ? ent_q[~wr_ptr].data : ent_q[wr_ptr].data;
`else
    assign hazard = (|match_a) | (|match_b);
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed table-driven bench for alu_writeback plus a hand-written streaming sequence.
module tb_alu_writeback;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready;
    logic [7:0] in_data, in_flags;
    logic [4:0] in_addr;
    logic       in_wr_rf, in_wr_sreg;
    logic       bit_op_valid, bit_op_set;
    logic [2:0] bit_op_idx;
    logic [7:0] sreg;
    logic       rf_wr_en, rf_wr_ready;
    logic [4:0] rf_wr_addr;
    logic [7:0] rf_wr_data;
    logic [4:0] chk_addr_a, chk_addr_b;
    logic       hazard;

    int n_cmp = 0;
    int n_err = 0;

    alu_writeback #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_flags     (in_flags),
        .in_addr      (in_addr),
        .in_wr_rf     (in_wr_rf),
        .in_wr_sreg   (in_wr_sreg),
        .bit_op_valid (bit_op_valid),
        .bit_op_set   (bit_op_set),
        .bit_op_idx   (bit_op_idx),
        .sreg         (sreg),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_ready  (rf_wr_ready),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .chk_addr_a   (chk_addr_a),
        .chk_addr_b   (chk_addr_b),
        .hazard       (hazard)
    );

    always #5 clk = ~clk;

    // One row = inputs held for one cycle, expected outputs seen mid-cycle before the edge.
    typedef struct {
        int rst, iv, wrf, wsr, dat, flg, adr, bv, bset, bidx, rdy, ca, cb;
        int e_rdy, e_sreg, e_en, chk_ad, e_adr, e_dat, e_haz;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic drive(input vec_t t);
        reset        = 1'(t.rst);
        in_valid     = 1'(t.iv);
        in_wr_rf     = 1'(t.wrf);
        in_wr_sreg   = 1'(t.wsr);
        in_data      = 8'(t.dat);
        in_flags     = 8'(t.flg);
        in_addr      = 5'(t.adr);
        bit_op_valid = 1'(t.bv);
        bit_op_set   = 1'(t.bset);
        bit_op_idx   = 3'(t.bidx);
        rf_wr_ready  = 1'(t.rdy);
        chk_addr_a   = 5'(t.ca);
        chk_addr_b   = 5'(t.cb);
    endtask

    initial begin
        //            rst iv wrf wsr dat    flg    adr bv bs bi rdy ca cb | rdy sreg   en ad adr dat    haz
        tbl[0]  = '{1, 1, 1, 1, 'hAA, 'hFF, 3, 0, 0, 0, 0, 3, 0,   0, 'h00, 0, 1, 0, 'h00, 0};
        tbl[1]  = '{0, 0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 1, 0, 0,   1, 'h00, 0, 1, 0, 'h00, 0};
        tbl[2]  = '{0, 1, 1, 1, 'h3C, 'h02, 5, 0, 0, 0, 1, 0, 0,   1, 'h00, 0, 0, 0, 'h00, 0};
        tbl[3]  = '{0, 0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 1, 5, 0,   1, 'h02, 1, 1, 5, 'h3C, 1};
        tbl[4]  = '{0, 0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 1, 5, 0,   1, 'h02, 0, 0, 0, 'h00, 0};
        tbl[5]  = '{0, 1, 1, 0, 'h11, 'h00, 1, 0, 0, 0, 0, 0, 0,   1, 'h02, 0, 0, 0, 'h00, 0};
        tbl[6]  = '{0, 1, 1, 0, 'h22, 'h00, 2, 0, 0, 0, 0, 0, 0,   1, 'h02, 1, 1, 1, 'h11, 0};
        tbl[7]  = '{0, 1, 1, 0, 'h33, 'h00, 3, 0, 0, 0, 0, 3, 9,   0, 'h02, 1, 1, 1, 'h11, 0};
        tbl[8]  = '{0, 0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 0, 2, 0,   0, 'h02, 1, 1, 1, 'h11, 1};
        tbl[9]  = '{0, 0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 1, 0, 0,   0, 'h02, 1, 1, 1, 'h11, 0};
        tbl[10] = '{0, 0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 1, 0, 2,   1, 'h02, 1, 1, 2, 'h22, 1};
        tbl[11] = '{0, 0, 0, 0, 'h00, 'h00, 0, 1, 0, 1, 1, 0, 0,   1, 'h02, 0, 0, 0, 'h00, 0};
        tbl[12] = '{0, 1, 0, 1, 'h99, 'h83, 4, 1, 0, 0, 1, 4, 0,   1, 'h00, 0, 0, 0, 'h00, 0};
        tbl[13] = '{0, 0, 0, 0, 'h00, 'h00, 0, 1, 1, 6, 1, 4, 0,   1, 'h82, 0, 0, 0, 'h00, 0};
        tbl[14] = '{0, 0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 1, 0, 0,   1, 'hC2, 0, 0, 0, 'h00, 0};
        tbl[15] = '{0, 1, 1, 0, 'h44, 'h00, 6, 0, 0, 0, 0, 0, 0,   1, 'hC2, 0, 0, 0, 'h00, 0};
        tbl[16] = '{0, 1, 1, 1, 'h55, 'h01, 6, 0, 0, 0, 0, 0, 0,   1, 'hC2, 1, 1, 6, 'h44, 0};
        tbl[17] = '{0, 1, 0, 1, 'hEE, 'h14, 9, 0, 0, 0, 0, 6, 0,   0, 'h01, 1, 1, 6, 'h44, 1};
        tbl[18] = '{0, 1, 0, 1, 'hEE, 'h14, 9, 0, 0, 0, 1, 6, 0,   0, 'h01, 1, 1, 6, 'h44, 1};
        tbl[19] = '{0, 1, 0, 1, 'hEE, 'h14, 9, 0, 0, 0, 0, 6, 0,   1, 'h01, 1, 1, 6, 'h55, 1};
        tbl[20] = '{0, 0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 1, 0, 0,   1, 'h14, 1, 1, 6, 'h55, 0};
        tbl[21] = '{0, 0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 1, 6, 0,   1, 'h14, 0, 0, 0, 'h00, 0};
        tbl[22] = '{0, 1, 1, 0, 'h77, 'h00, 7, 0, 0, 0, 0, 0, 0,   1, 'h14, 0, 0, 0, 'h00, 0};
        tbl[23] = '{0, 1, 1, 0, 'h78, 'h00, 8, 0, 0, 0, 0, 7, 0,   1, 'h14, 1, 1, 7, 'h77, 1};
        tbl[24] = '{1, 1, 1, 1, 'h79, 'hFF, 9, 1, 1, 3, 0, 0, 0,   0, 'h14, 1, 1, 7, 'h77, 0};
        tbl[25] = '{0, 0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 1, 7, 8,   1, 'h00, 0, 1, 0, 'h00, 0};
        tbl[26] = '{0, 0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 1, 0, 0,   1, 'h00, 0, 0, 0, 'h00, 0};

        // First reset cycle with in_valid high; row 0 is the second.
        drive(tbl[0]);
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            #4;
            chk($sformatf("v%0d in_ready", i), int'(in_ready), tbl[i].e_rdy);
            chk($sformatf("v%0d sreg", i),     int'(sreg),     tbl[i].e_sreg);
            chk($sformatf("v%0d rf_wr_en", i), int'(rf_wr_en), tbl[i].e_en);
            chk($sformatf("v%0d hazard", i),   int'(hazard),   tbl[i].e_haz);
            if (tbl[i].chk_ad != 0) begin
                chk($sformatf("v%0d rf_wr_addr", i), int'(rf_wr_addr), tbl[i].e_adr);
                chk($sformatf("v%0d rf_wr_data", i), int'(rf_wr_data), tbl[i].e_dat);
            end
            @(posedge clk);
            #1;
        end

        // Streaming: a write every cycle with the port always ready, each shows up one cycle later.
        for (int k = 0; k < 4; k++) begin
            reset = 1'b0; in_valid = 1'b1; in_wr_rf = 1'b1; in_wr_sreg = 1'b0;
            bit_op_valid = 1'b0; rf_wr_ready = 1'b1;
            in_data = 8'(8'hA0 + k); in_addr = 5'(10 + k);
            chk_addr_a = 5'd0; chk_addr_b = 5'd0;
            #4;
            chk($sformatf("s%0d in_ready", k), int'(in_ready), 1);
            if (k == 0) begin
                chk("s0 rf_wr_en", int'(rf_wr_en), 0);
            end else begin
                chk($sformatf("s%0d rf_wr_en", k),   int'(rf_wr_en),   1);
                chk($sformatf("s%0d rf_wr_addr", k), int'(rf_wr_addr), 10 + k - 1);
                chk($sformatf("s%0d rf_wr_data", k), int'(rf_wr_data), 'hA0 + k - 1);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #4;
        chk("s_tail rf_wr_en",   int'(rf_wr_en),   1);
        chk("s_tail rf_wr_addr", int'(rf_wr_addr), 13);
        chk("s_tail rf_wr_data", int'(rf_wr_data), 'hA3);
        @(posedge clk);
        #5;
        chk("s_drain rf_wr_en", int'(rf_wr_en), 0);
        chk("s_drain in_ready", int'(in_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
